// File: rtl/pipeline_pkg.sv
// Shared types and codes for the pipeline hazard controller: memory FSM states,
// operand-forward select codes, the load result-select code and a RAW match helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } mem_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic rd_hit(input logic [4:0] rd, input logic we,
                                  input logic [4:0] rs, input logic used);
    return used && we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory handshake FSM: tracks an outstanding request, counts wait cycles
// and latches into ERROR when MEM_TIMEOUT wait cycles pass without dmem_ack.
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_access,
  input  logic dmem_ack,
  output logic mem_req,
  output logic mem_stall,
  output logic ack_wait,
  output logic mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_req    = 1'b0;
    mem_stall  = 1'b0;
    ack_wait   = 1'b0;
    mem_err    = 1'b0;
    case (state_q)
      RUN: begin
        mem_req = mem_access;
        if (mem_access && !dmem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
          mem_stall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (dmem_ack) begin
          state_d  = RUN;
          ack_wait = 1'b1;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (int'(wait_cnt_q) + 1 >= MEM_TIMEOUT) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        mem_err = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory stalls, branch flushes, RAW stalls
// and operand forwarding. Define PIPELINE_CTRL_FORWARDING_EN to forward instead of stall.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_access,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cnt
);

  logic mem_req, mem_stall, ack_wait, mem_err;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_access(mem_access),
    .dmem_ack  (dmem_ack),
    .mem_req   (mem_req),
    .mem_stall (mem_stall),
    .ack_wait  (ack_wait),
    .mem_err   (mem_err)
  );

  logic       load_use, raw_hazard, hazard;
  logic [1:0] fwd_a, fwd_b;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  // Mem stage holds the younger result, so it wins over writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (rd_hit(m_rd, m_we, rs, 1'b1)) return FWD_MEM;
    if (rd_hit(w_rd, w_we, rs, 1'b1)) return FWD_WB;
    return FWD_RF;
  endfunction
`else
  logic unused_ex_rs;
  assign unused_ex_rs = ^{ex_rs1, ex_rs2};
`endif

  always_comb begin
    load_use = (ex_result_src == RESULT_SRC_LOAD) &&
               (rd_hit(ex_rd, ex_reg_write, id_rs1, id_use_rs1) ||
                rd_hit(ex_rd, ex_reg_write, id_rs2, id_use_rs2));
`ifdef PIPELINE_CTRL_FORWARDING_EN
    raw_hazard = 1'b0;
    fwd_a      = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b      = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
`else
    raw_hazard = rd_hit(ex_rd,  ex_reg_write,  id_rs1, id_use_rs1) ||
                 rd_hit(ex_rd,  ex_reg_write,  id_rs2, id_use_rs2) ||
                 rd_hit(mem_rd, mem_reg_write, id_rs1, id_use_rs1) ||
                 rd_hit(mem_rd, mem_reg_write, id_rs2, id_use_rs2) ||
                 rd_hit(wb_rd,  wb_reg_write,  id_rs1, id_use_rs1) ||
                 rd_hit(wb_rd,  wb_reg_write,  id_rs2, id_use_rs2);
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
`endif
    hazard = load_use || raw_hazard;
  end

  // Branch redirect waits out the ack cycle of a stalled access; execute still holds it.
  always_comb begin
    dmem_req = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    fwd_a_e  = FWD_RF;
    fwd_b_e  = FWD_RF;
    if (rst_n) begin
      dmem_req = mem_req;
      fwd_a_e  = fwd_a;
      fwd_b_e  = fwd_b;
      if (mem_err) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (ex_pc_src && !ack_wait) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (!imem_ready) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
    end
  end

  assign bus_error = mem_err;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of combinational hazard vectors plus
// hand-written memory-stall, timeout, branch-deferral and reset sequences.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_PC   = 7'b0000110;
  localparam logic [6:0] C_IMEM = 7'b1000100;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_ERR  = 7'b1111000;

  logic       clk, rst_n, imem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_pc_src;
  logic [1:0] ex_result_src;
  logic       mem_reg_write, mem_access, wb_reg_write, dmem_ack;
  logic       dmem_req, stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, bus_error;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [7:0] stall_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .bus_error(bus_error), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctrl;
  assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  typedef struct {
    string      nm;
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_rw;
    logic [1:0] ex_src;
    logic       pc;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       imem;
    logic [6:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vt[15];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle(input logic sf);
    exp_cnt = exp_cnt + 8'(sf);
    @(negedge clk);
  endtask

  task automatic set_idle();
    imem_ready = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_result_src = 2'b00;
    ex_pc_src = 1'b0; mem_rd = 5'd0; mem_reg_write = 1'b0; mem_access = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_reg_write = v.ex_rw;
    ex_result_src = v.ex_src; ex_pc_src = v.pc; mem_rd = v.mem_rd;
    mem_reg_write = v.mem_rw; wb_rd = v.wb_rd; wb_reg_write = v.wb_rw; imem_ready = v.imem;
    mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    //        nm              rs1 rs2 u1 u2 exrs1 exrs2 exrd rw src   pc mrd mrw wrd wrw im ctrl  fa  fb
    vt[0]  = '{"idle",         0,  0, 0, 0,  0,    0,   0,   0, 2'b00, 0, 0,  0,  0,  0,  1, C_NONE, 2'b00, 2'b00};
    vt[1]  = '{"load_use",     5,  0, 1, 0,  0,    0,   5,   1, 2'b01, 0, 0,  0,  0,  0,  1, C_LU, 2'b00, 2'b00};
    vt[2]  = '{"load_unused",  5,  0, 0, 0,  0,    0,   5,   1, 2'b01, 0, 0,  0,  0,  0,  1, C_NONE, 2'b00, 2'b00};
    vt[3]  = '{"load_x0",      0,  0, 1, 0,  0,    0,   0,   1, 2'b01, 0, 0,  0,  0,  0,  1, C_NONE, 2'b00, 2'b00};
    vt[4]  = '{"ex_raw",       0,  6, 0, 1,  0,    0,   6,   1, 2'b00, 0, 0,  0,  0,  0,  1,
               FWD ? C_NONE : C_LU, 2'b00, 2'b00};
    vt[5]  = '{"wb_raw",       0,  3, 0, 1,  0,    3,   0,   0, 2'b00, 0, 0,  0,  3,  1,  1,
               FWD ? C_NONE : C_LU, 2'b00, FWD ? 2'b01 : 2'b00};
    vt[6]  = '{"mem_raw",      9,  0, 1, 0,  9,    0,   0,   0, 2'b00, 0, 9,  1,  0,  0,  1,
               FWD ? C_NONE : C_LU, FWD ? 2'b10 : 2'b00, 2'b00};
    vt[7]  = '{"mem_over_wb",  0,  0, 0, 0,  7,    0,   0,   0, 2'b00, 0, 7,  1,  7,  1,  1,
               C_NONE, FWD ? 2'b10 : 2'b00, 2'b00};
    vt[8]  = '{"mem_rd0_wb",   0,  0, 0, 0,  7,    0,   0,   0, 2'b00, 0, 0,  1,  7,  1,  1,
               C_NONE, FWD ? 2'b01 : 2'b00, 2'b00};
    vt[9]  = '{"pc_src",       0,  0, 0, 0,  0,    0,   0,   0, 2'b00, 1, 0,  0,  0,  0,  1, C_PC, 2'b00, 2'b00};
    vt[10] = '{"pc_over_lu",   5,  0, 1, 0,  0,    0,   5,   1, 2'b01, 1, 0,  0,  0,  0,  1, C_PC, 2'b00, 2'b00};
    vt[11] = '{"imem_wait",    0,  0, 0, 0,  0,    0,   0,   0, 2'b00, 0, 0,  0,  0,  0,  0, C_IMEM, 2'b00, 2'b00};
    vt[12] = '{"lu_over_imem", 5,  0, 1, 0,  0,    0,   5,   1, 2'b01, 0, 0,  0,  0,  0,  0, C_LU, 2'b00, 2'b00};
    vt[13] = '{"pc_over_imem", 0,  0, 0, 0,  0,    0,   0,   0, 2'b00, 1, 0,  0,  0,  0,  0, C_PC, 2'b00, 2'b00};
    vt[14] = '{"wb_no_write",  0,  3, 0, 1,  0,    3,   0,   0, 2'b00, 0, 0,  0,  3,  0,  1, C_NONE, 2'b00, 2'b00};

    // Reset with every hazard source provoked: all outputs must stay quiet.
    rst_n = 1'b0;
    apply(vt[10]);
    mem_access = 1'b1; imem_ready = 1'b0; ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ctrl", ctrl, C_NONE);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_fwd", {fwd_a_e, fwd_b_e}, 4'b0000);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'd0;

    for (int i = 0; i < 15; i++) begin
      apply(vt[i]);
      #2;
      chk({vt[i].nm, "_ctrl"}, ctrl, vt[i].ctrl);
      chk({vt[i].nm, "_fwd_a"}, fwd_a_e, vt[i].fa);
      chk({vt[i].nm, "_fwd_b"}, fwd_b_e, vt[i].fb);
      chk({vt[i].nm, "_req"}, dmem_req, 1'b0);
      next_cycle(vt[i].ctrl[6]);
    end
    set_idle();
    #2;
    chk("table_stall_cnt", stall_cnt, exp_cnt);
    next_cycle(1'b0);

    // Load-use lasts one cycle: the bubble in execute releases it.
    apply(vt[1]);
    #2; chk("lu_seq_c1", ctrl, C_LU);
    next_cycle(1'b1);
    ex_reg_write = 1'b0; ex_rd = 5'd0; ex_result_src = 2'b00;
    #2; chk("lu_seq_c2", ctrl, C_NONE);
    next_cycle(1'b0);

    // Same-cycle ack in RUN: no stall and no lingering wait state.
    set_idle(); mem_access = 1'b1; dmem_ack = 1'b1;
    #2; chk("fast_ack_req", dmem_req, 1'b1); chk("fast_ack_ctrl", ctrl, C_NONE);
    next_cycle(1'b0);
    mem_access = 1'b0; dmem_ack = 1'b0;
    #2; chk("fast_ack_after", dmem_req, 1'b0);
    next_cycle(1'b0);

    // Ack on the third cycle of the request.
    mem_access = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      dmem_ack = (c == 3);
      #2;
      chk($sformatf("ack3_req_c%0d", c), dmem_req, 1'b1);
      chk($sformatf("ack3_ctrl_c%0d", c), ctrl, (c == 3) ? C_NONE : C_MEM);
      next_cycle(c != 3);
    end
    mem_access = 1'b0; dmem_ack = 1'b0;
    #2; chk("ack3_req_done", dmem_req, 1'b0); chk("ack3_stall_cnt", stall_cnt, exp_cnt);
    next_cycle(1'b0);

    // Branch resolved during a memory stall is deferred past the ack cycle.
    mem_access = 1'b1; ex_pc_src = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      dmem_ack = (c == 3);
      #2; chk($sformatf("pc_mem_ctrl_c%0d", c), ctrl, (c == 3) ? C_NONE : C_MEM);
      next_cycle(c != 3);
    end
    mem_access = 1'b0; dmem_ack = 1'b0;
    #2; chk("pc_mem_flush", ctrl, C_PC);
    next_cycle(1'b0);

    // Timeout: one RUN stall cycle plus four wait cycles, then ERROR.
    set_idle(); mem_access = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      #2;
      chk($sformatf("tmo_req_c%0d", c), dmem_req, 1'b1);
      chk($sformatf("tmo_ctrl_c%0d", c), ctrl, C_MEM);
      chk($sformatf("tmo_berr_c%0d", c), bus_error, 1'b0);
      next_cycle(1'b1);
    end
    #2;
    chk("err_bus_error", bus_error, 1'b1);
    chk("err_req", dmem_req, 1'b0);
    chk("err_ctrl", ctrl, C_ERR);
    next_cycle(1'b1);
    mem_access = 1'b0; dmem_ack = 1'b1; ex_pc_src = 1'b1;
    #2; chk("err_sticky", {bus_error, ctrl}, {1'b1, C_ERR});
    next_cycle(1'b1);
    for (int c = 0; c < 256; c++) next_cycle(1'b1);
    #2; chk("err_cnt_wrap", stall_cnt, exp_cnt);
    #1 rst_n = 1'b0;
    #1;
    chk("err_rst_berr", bus_error, 1'b0);
    chk("err_rst_cnt", stall_cnt, 8'd0);
    chk("err_rst_ctrl", {dmem_req, ctrl}, 8'd0);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1; set_idle();
    #2; chk("post_err_run", {bus_error, dmem_req, ctrl}, 9'd0);
    next_cycle(1'b0);

    // Reset in MEM_WAIT abandons the request.
    mem_access = 1'b1;
    #2; chk("abandon_c1", ctrl, C_MEM);
    next_cycle(1'b1);
    #2; chk("abandon_c2_req", dmem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("abandon_rst_req", dmem_req, 1'b0);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1; mem_access = 1'b0;
    #2; chk("abandon_idle", {dmem_req, ctrl}, 8'd0);
    next_cycle(1'b0);
    mem_access = 1'b1; dmem_ack = 1'b1;
    #2; chk("abandon_run", {dmem_req, ctrl}, {1'b1, C_NONE});
    next_cycle(1'b0);
    set_idle();
    #2; chk("final_stall_cnt", stall_cnt, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
